// File: rtl/ntt_pkg.sv
// Shared NTT sizing and types: stage count, data width and twiddle address type.
// Every NTT datapath block takes its geometry from here.
package ntt_pkg;

    localparam int NTT_STAGE_CNT = 8;
    localparam int NTT_N         = 1 << NTT_STAGE_CNT;
    localparam int DATA_WIDTH    = 32;

    // Twiddle ROM address, one per lane per stage
    typedef logic [NTT_STAGE_CNT-2:0] tw_addr_t;

endpackage

// File: rtl/tf_addr_stage.sv
// One NTT stage of the twiddle address generator: pair counter, latched mode
// and registered lane addresses with valid/frame-done flags.
module tf_addr_stage
    import ntt_pkg::*;
#(
    parameter int STAGE = 0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clear,
    input  logic     mode,
    input  logic     in_valid,
    output tw_addr_t rom_addr [2],
    output logic     addr_valid,
    output logic     frame_done
);

    localparam int CNT_W = NTT_STAGE_CNT - 2;
    localparam int SHIFT = NTT_STAGE_CNT - 1 - STAGE;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t     CNT_LAST = '1;
    localparam tw_addr_t TW_TOP   = tw_addr_t'((1 << STAGE) - 1);

    cnt_t     cnt_r;
    logic     mode_r;
    logic     eff_mode_s;
    tw_addr_t addr_s [2];
    tw_addr_t addr_r [2];
    logic     addr_valid_r;
    logic     frame_done_r;

    // Stage 0 uses the unit twiddle only; later stages keep the top i bits of j
    function automatic tw_addr_t lane_addr(input cnt_t k, input logic lane, input logic inv);
        tw_addr_t j;
        tw_addr_t base;
        j    = {k, lane};
        base = j >> SHIFT;
        if (STAGE == 0) begin
            lane_addr = '0;
        end else if (inv) begin
            lane_addr = TW_TOP - base;
        end else begin
            lane_addr = base;
        end
    endfunction

    // Next-address calculation; pair 0 already sees the mode being latched
    always_comb begin
        eff_mode_s = mode_r;
        if (cnt_r == '0) begin
            eff_mode_s = mode;
        end else begin
            eff_mode_s = mode_r;
        end
        addr_s[0] = lane_addr(cnt_r, 1'b0, eff_mode_s);
        addr_s[1] = lane_addr(cnt_r, 1'b1, eff_mode_s);
    end

    // Counter, mode latch and output registers; rst beats clear beats in_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= '0;
            mode_r       <= 1'b0;
            addr_r[0]    <= '0;
            addr_r[1]    <= '0;
            addr_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
        end else if (clear) begin
            cnt_r        <= '0;
            addr_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
        end else if (in_valid) begin
            cnt_r <= cnt_r + cnt_t'(1);
            if (cnt_r == '0) begin
                mode_r <= mode;
            end
            addr_r[0]    <= addr_s[0];
            addr_r[1]    <= addr_s[1];
            addr_valid_r <= 1'b1;
            frame_done_r <= (cnt_r == CNT_LAST);
        end else begin
            addr_valid_r <= 1'b0;
            frame_done_r <= 1'b0;
        end
    end

    // Drive ports straight from the registers
    always_comb begin
        rom_addr[0] = addr_r[0];
        rom_addr[1] = addr_r[1];
        addr_valid  = addr_valid_r;
        frame_done  = frame_done_r;
    end

endmodule

// File: rtl/tf_addr_gen.sv
// Twiddle address generator for all NTT stages; rom_addr plugs directly into
// tf_rom. Each stage runs its own independent frame counter.
module tf_addr_gen
    import ntt_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     mode,
    input  logic [NTT_STAGE_CNT-1:0] in_valid,
    output tw_addr_t                 rom_addr [2][NTT_STAGE_CNT],
    output logic [NTT_STAGE_CNT-1:0] addr_valid,
    output logic [NTT_STAGE_CNT-1:0] frame_done
);

    tw_addr_t                 stage_addr_s [NTT_STAGE_CNT][2];
    logic [NTT_STAGE_CNT-1:0] stage_valid_s;
    logic [NTT_STAGE_CNT-1:0] stage_done_s;

    for (genvar g = 0; g < NTT_STAGE_CNT; g++) begin : g_stage
        tf_addr_stage #(
            .STAGE(g)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .mode      (mode),
            .in_valid  (in_valid[g]),
            .rom_addr  (stage_addr_s[g]),
            .addr_valid(stage_valid_s[g]),
            .frame_done(stage_done_s[g])
        );
    end

    // Reorder stage-major addresses into the lane-major ROM port shape
    always_comb begin
        for (int s = 0; s < NTT_STAGE_CNT; s++) begin
            rom_addr[0][s] = stage_addr_s[s][0];
            rom_addr[1][s] = stage_addr_s[s][1];
        end
        addr_valid = stage_valid_s;
        frame_done = stage_done_s;
    end

endmodule

// File: tb/tb_tf_addr_gen.sv
// Self-checking bench for tf_addr_gen with a reference model feeding a scoreboard.
module tb_tf_addr_gen;
    import ntt_pkg::*;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       mode;
    logic [7:0] in_valid;
    tw_addr_t   rom_addr [2][8];
    logic [7:0] addr_valid;
    logic [7:0] frame_done;

    tf_addr_gen dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .mode      (mode),
        .in_valid  (in_valid),
        .rom_addr  (rom_addr),
        .addr_valid(addr_valid),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]      av;
        logic [7:0]      fd;
        logic [7:0][6:0] a0;
        logic [7:0][6:0] a1;
    } exp_t;

    exp_t            sb [$];
    exp_t            e;
    int              mk [8];
    logic            mm [8];
    logic [7:0][6:0] last_a0;
    logic [7:0][6:0] last_a1;
    int              n_cmp;
    int              n_bad;

    // Drive one cycle, push the model's prediction, advance past the edge
    task automatic drive(input logic [7:0] iv, input logic md, input logic clr, input logic rs);
        exp_t x;
        int   j;
        int   base;
        int   val;
        rst = rs; clear = clr; mode = md; in_valid = iv;
        x.av = 8'h00; x.fd = 8'h00; x.a0 = last_a0; x.a1 = last_a1;
        if (rs) begin
            for (int s = 0; s < 8; s++) begin mk[s] = 0; mm[s] = 1'b0; end
            x.a0 = '0; x.a1 = '0;
        end else if (clr) begin
            for (int s = 0; s < 8; s++) mk[s] = 0;
        end else begin
            for (int s = 0; s < 8; s++) begin
                if (iv[s]) begin
                    if (mk[s] == 0) mm[s] = md;
                    for (int p = 0; p < 2; p++) begin
                        j    = 2 * mk[s] + p;
                        base = j / (1 << (7 - s));
                        if (s == 0) val = 0;
                        else if (mm[s]) val = (1 << s) - 1 - base;
                        else val = base;
                        if (p == 0) x.a0[s] = 7'(val); else x.a1[s] = 7'(val);
                    end
                    x.av[s] = 1'b1;
                    x.fd[s] = (mk[s] == 63);
                    mk[s]   = (mk[s] + 1) % 64;
                end
            end
        end
        last_a0 = x.a0; last_a1 = x.a1;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front();
        n_cmp++; if (addr_valid !== 8'h00) begin n_bad++; $display("FAIL reset_av got %h want 00", addr_valid); end
        n_cmp++; if (frame_done !== 8'h00) begin n_bad++; $display("FAIL reset_fd got %h want 00", frame_done); end
        for (int s = 0; s < 8; s++) begin
            n_cmp++;
            if (rom_addr[0][s] !== 7'd0 || rom_addr[1][s] !== 7'd0) begin
                n_bad++; $display("FAIL reset_addr s=%0d got %0d/%0d want 0/0", s, rom_addr[0][s], rom_addr[1][s]);
            end
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        n_cmp++; if (addr_valid !== e.av) begin n_bad++; $display("FAIL idle_av got %h want %h", addr_valid, e.av); end
    endtask

    task automatic test_fwd_stage7();
        int tt;
        int nfd;
        nfd = 0;
        drive(8'h00, 1'b0, 1'b0, 1'b1); e = sb.pop_front();
        for (int t = 0; t < 66; t++) begin
            tt = t % 64;
            drive(8'h80, 1'b0, 1'b0, 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (rom_addr[0][7] !== e.a0[7] || rom_addr[0][7] !== 7'(2 * tt)) begin
                n_bad++; $display("FAIL fwd7_l0 t=%0d got %0d want %0d", t, rom_addr[0][7], 2 * tt);
            end
            n_cmp++;
            if (rom_addr[1][7] !== e.a1[7] || rom_addr[1][7] !== 7'(2 * tt + 1)) begin
                n_bad++; $display("FAIL fwd7_l1 t=%0d got %0d want %0d", t, rom_addr[1][7], 2 * tt + 1);
            end
            n_cmp++;
            if (addr_valid !== e.av || frame_done !== e.fd) begin
                n_bad++; $display("FAIL fwd7_flags t=%0d got %h/%h want %h/%h", t, addr_valid, frame_done, e.av, e.fd);
            end
            if (t < 64 && frame_done[7]) begin
                nfd++;
                n_cmp++;
                if (tt != 63) begin n_bad++; $display("FAIL fwd7_done_pos got t=%0d want 63", tt); end
            end
        end
        n_cmp++; if (nfd != 1) begin n_bad++; $display("FAIL fwd7_done_cnt got %0d want 1", nfd); end
    endtask

    task automatic test_stage3();
        drive(8'h00, 1'b0, 1'b0, 1'b1); e = sb.pop_front();
        for (int t = 0; t < 37; t++) begin drive(8'h08, 1'b0, 1'b0, 1'b0); e = sb.pop_front(); end
        drive(8'h08, 1'b0, 1'b0, 1'b0); e = sb.pop_front();
        n_cmp++;
        if (rom_addr[0][3] !== 7'd4 || rom_addr[1][3] !== 7'd4 || rom_addr[0][3] !== e.a0[3]) begin
            n_bad++; $display("FAIL s3_fwd_k37 got %0d/%0d want 4/4", rom_addr[0][3], rom_addr[1][3]);
        end
        // mode raised mid-frame: rest of this frame must stay forward
        for (int t = 38; t < 64; t++) begin
            drive(8'h08, 1'b1, 1'b0, 1'b0); e = sb.pop_front();
            n_cmp++;
            if (rom_addr[0][3] !== e.a0[3] || rom_addr[1][3] !== e.a1[3]) begin
                n_bad++; $display("FAIL s3_hold_mode k=%0d got %0d/%0d want %0d/%0d", t, rom_addr[0][3], rom_addr[1][3], e.a0[3], e.a1[3]);
            end
        end
        for (int t = 0; t < 37; t++) begin drive(8'h08, 1'b1, 1'b0, 1'b0); e = sb.pop_front(); end
        drive(8'h08, 1'b1, 1'b0, 1'b0); e = sb.pop_front();
        n_cmp++;
        if (rom_addr[0][3] !== 7'd3 || rom_addr[1][3] !== 7'd3 || rom_addr[1][3] !== e.a1[3]) begin
            n_bad++; $display("FAIL s3_inv_k37 got %0d/%0d want 3/3", rom_addr[0][3], rom_addr[1][3]);
        end
    endtask

    task automatic test_gap();
        logic [4:0] pat;
        logic [6:0] want0 [5];
        pat = 5'b11101;
        want0[0] = 7'd0; want0[1] = 7'd0; want0[2] = 7'd0; want0[3] = 7'd1; want0[4] = 7'd1;
        drive(8'h00, 1'b0, 1'b0, 1'b1); e = sb.pop_front();
        for (int t = 0; t < 5; t++) begin
            drive(pat[t] ? 8'h20 : 8'h00, 1'b0, 1'b0, 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (addr_valid[5] !== pat[t] || addr_valid !== e.av) begin
                n_bad++; $display("FAIL gap_av t=%0d got %h want bit5=%0d", t, addr_valid, pat[t]);
            end
            n_cmp++;
            if (rom_addr[0][5] !== want0[t] || rom_addr[1][5] !== e.a1[5]) begin
                n_bad++; $display("FAIL gap_addr t=%0d got %0d/%0d want %0d/%0d", t, rom_addr[0][5], rom_addr[1][5], want0[t], e.a1[5]);
            end
        end
    endtask

    task automatic test_mode_flip();
        drive(8'h00, 1'b0, 1'b0, 1'b1); e = sb.pop_front();
        for (int t = 0; t < 64; t++) begin
            drive(8'h80, (t >= 10), 1'b0, 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (rom_addr[0][7] !== 7'(2 * t) || rom_addr[0][7] !== e.a0[7]) begin
                n_bad++; $display("FAIL flip_fwd t=%0d got %0d want %0d", t, rom_addr[0][7], 2 * t);
            end
        end
        drive(8'h80, 1'b1, 1'b0, 1'b0); e = sb.pop_front();
        n_cmp++;
        if (rom_addr[0][7] !== 7'd127 || rom_addr[1][7] !== 7'd126 || rom_addr[0][7] !== e.a0[7]) begin
            n_bad++; $display("FAIL flip_inv_p0 got %0d/%0d want 127/126", rom_addr[0][7], rom_addr[1][7]);
        end
    endtask

    task automatic test_clear();
        drive(8'h00, 1'b0, 1'b0, 1'b1); e = sb.pop_front();
        for (int t = 0; t < 20; t++) begin drive(8'h80, 1'b0, 1'b0, 1'b0); e = sb.pop_front(); end
        drive(8'h80, 1'b0, 1'b1, 1'b0); e = sb.pop_front();
        n_cmp++;
        if (addr_valid !== 8'h00 || frame_done !== 8'h00 || addr_valid !== e.av) begin
            n_bad++; $display("FAIL clear_flags got %h/%h want 00/00", addr_valid, frame_done);
        end
        n_cmp++;
        if (rom_addr[0][7] !== 7'd38 || rom_addr[1][7] !== 7'd39) begin
            n_bad++; $display("FAIL clear_hold got %0d/%0d want 38/39", rom_addr[0][7], rom_addr[1][7]);
        end
        drive(8'h80, 1'b0, 1'b0, 1'b0); e = sb.pop_front();
        n_cmp++;
        if (rom_addr[0][7] !== 7'd0 || rom_addr[1][7] !== 7'd1 || rom_addr[1][7] !== e.a1[7]) begin
            n_bad++; $display("FAIL clear_p0 got %0d/%0d want 0/1", rom_addr[0][7], rom_addr[1][7]);
        end
        n_cmp++;
        if (addr_valid !== 8'h80 || frame_done !== 8'h00) begin
            n_bad++; $display("FAIL clear_next_flags got %h/%h want 80/00", addr_valid, frame_done);
        end
    endtask

    task automatic test_back_to_back_rst();
        int nfd [8];
        for (int s = 0; s < 8; s++) nfd[s] = 0;
        drive(8'h00, 1'b0, 1'b0, 1'b1); e = sb.pop_front();
        for (int t = 0; t < 40; t++) begin drive(8'hFF, 1'b0, 1'b0, 1'b0); e = sb.pop_front(); end
        drive(8'hFF, 1'b0, 1'b0, 1'b1); e = sb.pop_front();
        n_cmp++;
        if (addr_valid !== 8'h00 || rom_addr[0][7] !== 7'd0) begin
            n_bad++; $display("FAIL rst_mid got av=%h a=%0d want 00/0", addr_valid, rom_addr[0][7]);
        end
        for (int t = 0; t < 64; t++) begin
            drive(8'hFF, 1'b1, 1'b0, 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (addr_valid !== 8'hFF || addr_valid !== e.av) begin
                n_bad++; $display("FAIL all_av t=%0d got %h want ff", t, addr_valid);
            end
            n_cmp++;
            if (frame_done !== ((t == 63) ? 8'hFF : 8'h00) || frame_done !== e.fd) begin
                n_bad++; $display("FAIL all_fd t=%0d got %h want %h", t, frame_done, e.fd);
            end
            for (int s = 0; s < 8; s++) begin
                if (frame_done[s]) nfd[s]++;
                n_cmp++;
                if (rom_addr[0][s] !== e.a0[s] || rom_addr[1][s] !== e.a1[s]) begin
                    n_bad++; $display("FAIL all_addr t=%0d s=%0d got %0d/%0d want %0d/%0d", t, s, rom_addr[0][s], rom_addr[1][s], e.a0[s], e.a1[s]);
                end
            end
        end
        for (int s = 0; s < 8; s++) begin
            n_cmp++;
            if (nfd[s] != 1) begin n_bad++; $display("FAIL all_done_cnt s=%0d got %0d want 1", s, nfd[s]); end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        last_a0 = '0; last_a1 = '0;
        for (int s = 0; s < 8; s++) begin mk[s] = 0; mm[s] = 1'b0; end
        rst = 1'b1; clear = 1'b0; mode = 1'b0; in_valid = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_fwd_stage7();
        test_stage3();
        test_gap();
        test_mode_flip();
        test_clear();
        test_back_to_back_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tf_addr_gen.md
TF_ADDR_GEN -- requirements
Module: tf_addr_gen

Interface
REQ-001 Parameters: none; all sizes SHALL come from ntt_pkg (NTT_STAGE_CNT, written S below; N = 2^S).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 clear  in  1  resynchronises all stage counters to frame start.
REQ-005 mode  in  1  0 = forward NTT, 1 = inverse NTT; sampled per stage at frame start.
REQ-006 in_valid  in  [S-1:0]  bit i = stage i consumes one butterfly pair (lanes 0 and 1) this cycle.
REQ-007 rom_addr  out  [2][S] x [S-2:0]  twiddle address per lane per stage; this is the tf_rom address port.
REQ-008 addr_valid  out  [S-1:0]  bit i = rom_addr[*][i] is valid this cycle.
REQ-009 frame_done  out  [S-1:0]  bit i = single-cycle pulse with the last pair of a frame in stage i.

Function
REQ-010 Each stage i SHALL own an independent pair counter k_i, S-2 bits wide, counting 0 .. 2^(S-2)-1.
REQ-011 k_i SHALL increment by 1 on each cycle with in_valid[i]=1, and SHALL hold otherwise.
REQ-012 k_i SHALL wrap from 2^(S-2)-1 to 0; wrap SHALL NOT stall and SHALL NOT need a gap cycle.
REQ-013 Butterfly index j = {k_i, p} for lane p in {0,1}, S-1 bits wide.
REQ-014 Forward address for stage i >= 1 SHALL be j >> (S-1-i), zero-extended to S-1 bits.
REQ-015 Inverse address for stage i >= 1 SHALL be (2^i - 1) - (j >> (S-1-i)), zero-extended.
REQ-016 Stage 0 address SHALL be 0 on both lanes in both modes; addr_valid[0] and frame_done[0] SHALL still track in_valid[0].
REQ-017 rom_addr, addr_valid and frame_done SHALL be registered with latency 1 from in_valid. ROM data is therefore valid 2 cycles after in_valid.
REQ-018 When in_valid[i]=0, rom_addr[*][i] SHALL hold its last value and addr_valid[i] SHALL be 0.
REQ-019 frame_done[i] SHALL assert in the cycle addr_valid[i]=1 carries k_i = 2^(S-2)-1.
REQ-020 Stage mode register m_i SHALL load mode when in_valid[i]=1 and k_i=0. A mode change mid-frame SHALL NOT affect that stage until its next frame.
REQ-021 clear=1 SHALL reset all k_i to 0 and force addr_valid=0 and frame_done=0 next cycle; rom_addr holds.
REQ-022 clear and in_valid in the same cycle: clear SHALL win, and that in_valid SHALL be ignored (no count, no output).
REQ-023 Stages SHALL be mutually independent; any in_valid pattern, including all bits set, SHALL be legal.

Reset
REQ-024 On rst: all k_i = 0, all m_i = 0, rom_addr = 0, addr_valid = 0, frame_done = 0.
REQ-025 rst mid-frame SHALL abandon the frame; the first in_valid after rst SHALL be treated as pair 0.
REQ-026 rst SHALL take priority over clear and in_valid.

Structure
REQ-027 S, DATA_WIDTH and a typedef for the S-1-bit twiddle address SHALL live in ntt_pkg; no new package constants are needed.
REQ-028 One sub-module, tf_addr_stage #(STAGE), SHALL hold one counter, its mode register and its address/valid/done registers. The top generates S instances.
REQ-029 The rom_addr port shape SHALL match the tf_rom input exactly, so the two blocks connect directly.

Verification (S=8, N=256, 64 pairs/frame)
REQ-030 rst; in_valid[7]=1 for 64 cycles, mode=0 -> cycle t+1 gives rom_addr[0][7]=2t, rom_addr[1][7]=2t+1; frame_done[7] pulses once with 126/127.
REQ-031 Stage 3, mode=0, pair k=37 (j=74/75) -> both lanes address 74>>4 = 4; mode=1 -> both lanes address 7-4 = 3.
REQ-032 in_valid[5] toggled 1,0,1,1 -> addr_valid[5] = 1,0,1,1 one cycle later; k advances 0,1,1,2,3; addresses hold during the gap.
REQ-033 mode flipped 0->1 at pair 10 of stage 7 -> pairs 10..63 stay forward; next frame pair 0 gives rom_addr[0][7]=127, rom_addr[1][7]=126.
REQ-034 clear together with in_valid at pair 20, then in_valid -> no output for the clear cycle; the next valid yields addresses for pair 0; no frame_done.
REQ-035 rst asserted at pair 40 of all stages, then 64 valids on all stages -> outputs restart at pair 0; exactly one frame_done per stage on pair 63.
